// File: rtl/zbank_bus_master_pkg.sv
// Shared types and constants for the Z80 bank-window 68k bus master.
package zbank_bus_master_pkg;

  localparam int unsigned BANK_WIDTH  = 9;
  localparam int unsigned VA_WIDTH    = BANK_WIDTH + 14;
  localparam logic [15:0] WINDOW_BASE = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK,
    ASRT,
    DATA,
    NEG,
    REL,
    ZEND
  } state_t;

  function automatic logic in_window(input logic [15:0] za);
    return za >= WINDOW_BASE;
  endfunction

endpackage

// File: rtl/zbank_bus_master_if.sv
// 68k-side bus of the bank-window master: arbitration, strobes, address and data.
interface zbank_bus_master_if;
  import zbank_bus_master_pkg::*;

  logic                BR;
  logic                BG;
  logic                BGACK_i;
  logic                BGACK_o;
  logic                AS_i;
  logic                DTACK_i;
  logic                AS_o;
  logic                UDS_o;
  logic                LDS_o;
  logic                RW_o;
  logic                strobe_d;
  logic [VA_WIDTH-1:0] VA_o;
  logic [15:0]         VD_i;
  logic [15:0]         VD_o;
  logic                VD_d;

  modport master (
    output BR, BGACK_o, AS_o, UDS_o, LDS_o, RW_o, strobe_d, VA_o, VD_o, VD_d,
    input  BG, BGACK_i, AS_i, DTACK_i, VD_i
  );

  modport slave (
    input  BR, BGACK_o, AS_o, UDS_o, LDS_o, RW_o, strobe_d, VA_o, VD_o, VD_d,
    output BG, BGACK_i, AS_i, DTACK_i, VD_i
  );

endinterface

// File: rtl/zbank_bus_master_zbank_reg.sv
// Serial bank register: one right shift per Z80 write strobe to the bank page.
module zbank_reg
  import zbank_bus_master_pkg::*;
#(
  parameter logic [7:0] BANK_PAGE = 8'h60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  zmreq,
  input  logic                  zwr,
  input  logic [7:0]            za_hi,
  input  logic                  d,
  output logic [BANK_WIDTH-1:0] bank
);

  logic zwr_q;

  // Shift only on the sampled falling edge so a long ZWR gives a single shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zwr_q <= 1'b1;
      bank  <= '0;
    end else begin
      zwr_q <= zwr;
      if (zwr_q && !zwr && !zmreq && (za_hi == BANK_PAGE))
        bank <= {d, bank[BANK_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/zbank_bus_master.sv
// Z80 bank-window master: stalls the Z80, takes the 68k bus and runs one cycle.
// Optional macro ZBANK_TIMEOUT_EN adds a DTACK timeout and the timeout_flag port.
module zbank_bus_master
  import zbank_bus_master_pkg::*;
#(
  parameter logic [7:0] BANK_PAGE = 8'h60
`ifdef ZBANK_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                  MCLK,
  input  logic                  RESET,
  input  logic                  VCLK_EN,
  input  logic [15:0]           ZA,
  input  logic [7:0]            ZD_i,
  output logic [7:0]            ZD_o,
  output logic                  ZD_d,
  input  logic                  ZMREQ,
  input  logic                  ZRD,
  input  logic                  ZWR,
  output logic                  ZWAIT,
  zbank_bus_master_if.master    bus,
  output logic [BANK_WIDTH-1:0] bank
`ifdef ZBANK_TIMEOUT_EN
  , output logic                timeout_flag
`endif
);

  state_t      state, state_nxt;
  logic [14:0] addr_q;
  logic        rd_q;
  logic [7:0]  wd_q;
  logic        start;
  logic        to_hit;
  logic        own;
  logic        br, bgack_o, as_o, uds_o, lds_o, rw_o, strobe_d, vd_d;

  assign start = !RESET && !ZMREQ && in_window(ZA) && (!ZRD || !ZWR);

  zbank_reg #(.BANK_PAGE(BANK_PAGE)) u_bank (
    .clk   (MCLK),
    .rst   (RESET),
    .zmreq (ZMREQ),
    .zwr   (ZWR),
    .za_hi (ZA[15:8]),
    .d     (ZD_i[0]),
    .bank  (bank)
  );

`ifdef ZBANK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  assign to_hit = (state == DATA) && VCLK_EN && bus.DTACK_i &&
                  (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      timeout_flag <= to_hit;
      if (VCLK_EN && (state == ASRT))
        to_cnt <= '0;
      else if (VCLK_EN && (state == DATA))
        to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Address and direction are captured at start so an aborting Z80 cannot disturb the bus cycle.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      addr_q <= '0;
      rd_q   <= 1'b0;
      wd_q   <= '0;
      ZD_o   <= '0;
    end else if (VCLK_EN) begin
      if ((state == IDLE) && start) begin
        addr_q <= ZA[14:0];
        rd_q   <= !ZRD;
        wd_q   <= ZD_i;
      end
      if (state == DATA) begin
        if (to_hit)
          ZD_o <= 8'hFF;
        else if (!bus.DTACK_i && rd_q)
          ZD_o <= addr_q[0] ? bus.VD_i[7:0] : bus.VD_i[15:8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ZWAIT     = 1'b0;
    ZD_d      = 1'b1;
    own       = 1'b0;
    br        = 1'b0;
    bgack_o   = 1'b0;
    as_o      = 1'b1;
    uds_o     = 1'b1;
    lds_o     = 1'b1;
    rw_o      = 1'b1;
    strobe_d  = 1'b1;
    vd_d      = 1'b1;
    case (state)
      IDLE: begin
        ZWAIT = start;
        if (start && VCLK_EN) state_nxt = REQ;
      end
      REQ: begin
        ZWAIT = 1'b1;
        br    = 1'b1;
        if (VCLK_EN && !bus.BG && bus.AS_i && bus.DTACK_i && bus.BGACK_i)
          state_nxt = ACK;
      end
      ACK, ASRT, DATA, NEG: begin
        ZWAIT    = 1'b1;
        own      = 1'b1;
        bgack_o  = 1'b1;
        strobe_d = 1'b0;
        rw_o     = rd_q;
        if (state != NEG) vd_d = rd_q;
        if ((state == ASRT) || (state == DATA)) begin
          as_o  = 1'b0;
          uds_o = addr_q[0];
          lds_o = !addr_q[0];
        end
        if (VCLK_EN) begin
          case (state)
            ACK:     state_nxt = ASRT;
            ASRT:    state_nxt = DATA;
            DATA:    if (!bus.DTACK_i || to_hit) state_nxt = NEG;
            default: state_nxt = REL;
          endcase
        end
      end
      REL: begin
        if (VCLK_EN) state_nxt = ZEND;
      end
      ZEND: begin
        ZD_d = !(rd_q && !ZMREQ && !ZRD);
        if (ZMREQ) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.BR       = br;
  assign bus.BGACK_o  = bgack_o;
  assign bus.AS_o     = as_o;
  assign bus.UDS_o    = uds_o;
  assign bus.LDS_o    = lds_o;
  assign bus.RW_o     = rw_o;
  assign bus.strobe_d = strobe_d;
  assign bus.VD_d     = vd_d;
  assign bus.VA_o     = own ? {bank, addr_q[14:1]} : '0;
  assign bus.VD_o     = {wd_q, wd_q};

endmodule
